// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, CSR field positions
// and helpers that turn the CSR frame-size field into word framing parameters.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } uart_state_t;

    localparam int CSR_NBITS_LSB = 0;
    localparam int CSR_NBITS_MSB = 3;
    localparam int CSR_STOP2     = 4;
    localparam int CSR_PAR_EN    = 5;
    localparam int CSR_PAR_ODD   = 6;
    localparam int CFG_W         = 7;
    localparam int TOTAL_W       = 6;

    // Frame sizes outside 5..8 fall back to 8 data bits.
    function automatic logic [3:0] eff_nbits(input logic [3:0] nbits);
        return (nbits >= 4'd5 && nbits <= 4'd8) ? nbits : 4'd8;
    endfunction

    // Frames needed to carry 32 bits, minus one (loaded into the frame counter).
    function automatic logic [2:0] frames_minus_one(input logic [3:0] nbits);
        logic [2:0] f;
        case (nbits)
            4'd5:    f = 3'd6;
            4'd6:    f = 3'd5;
            4'd7:    f = 3'd4;
            default: f = 3'd3;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// Word shift register for the transmitter: loads a word, shifts it out LSB-first with
// zero fill, and keeps the per-frame parity and the running count of bits sent.
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int DATA_W = 32
)
(
    input  logic              tick,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift_en,
    input  logic              par_clr,
    output logic              data_bit,
    output logic              parity
);

    logic [DATA_W-1:0]  shift_reg;
    logic [TOTAL_W-1:0] bit_total_reg;
    logic               parity_reg;

    // Bits past the end of the word are padding and always go out as zero.
    assign data_bit = (bit_total_reg >= TOTAL_W'(DATA_W)) ? 1'b0 : shift_reg[0];
    assign parity   = parity_reg;

    always_ff @(posedge tick or posedge rst) begin
        if (rst) begin
            shift_reg     <= '0;
            bit_total_reg <= '0;
            parity_reg    <= 1'b0;
        end else begin
            if (load) begin
                shift_reg     <= load_data;
                bit_total_reg <= '0;
            end else if (shift_en) begin
                shift_reg     <= {1'b0, shift_reg[DATA_W-1:1]};
                bit_total_reg <= bit_total_reg + TOTAL_W'(1);
            end

            if (par_clr) begin
                parity_reg <= 1'b0;
            end else if (shift_en) begin
                parity_reg <= parity_reg ^ data_bit;
            end
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: pops 32-bit words from the TX FIFO and sends each one as a
// run of back-to-back UART frames, configured per word from the CSR.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CSR_W  = 32
)
(
    input  logic              tick,
    input  logic              rst,
    input  logic [CSR_W-1:0]  csr,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              out,
    output logic              busy,
    output logic              word_done
);

    uart_state_t      state_reg, state_next;
    logic [CFG_W-1:0] cfg_reg, cfg_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic [2:0]       frames_left_reg, frames_left_next;
    logic             guard_reg, guard_next;
    logic             word_done_reg, word_done_next;

    logic             load, shift_en, par_clr, end_frame;
    logic             data_bit, parity;
    logic [3:0]       nbits;
    logic             last_data;
    logic             unused_csr_bits;

    assign unused_csr_bits = ^csr[CSR_W-1:CFG_W];

    assign nbits     = eff_nbits(cfg_reg[CSR_NBITS_MSB:CSR_NBITS_LSB]);
    assign last_data = ({1'b0, bit_cnt_reg} == (nbits - 4'd1));

    // Reset gates the pop so a queued word is never consumed while held in reset.
    assign fifo_rd   = !rst && (state_reg == IDLE) && !fifo_empty && guard_reg;
    assign busy      = (state_reg != IDLE);
    assign word_done = word_done_reg;

    uart_tx_shifter #(.DATA_W(DATA_W)) u_shifter (
        .tick      (tick),
        .rst       (rst),
        .load      (load),
        .load_data (fifo_data),
        .shift_en  (shift_en),
        .par_clr   (par_clr),
        .data_bit  (data_bit),
        .parity    (parity)
    );

    always_ff @(posedge tick or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            cfg_reg         <= '0;
            bit_cnt_reg     <= '0;
            frames_left_reg <= '0;
            guard_reg       <= 1'b1;
            word_done_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cfg_reg         <= cfg_next;
            bit_cnt_reg     <= bit_cnt_next;
            frames_left_reg <= frames_left_next;
            guard_reg       <= guard_next;
            word_done_reg   <= word_done_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cfg_next         = cfg_reg;
        bit_cnt_next     = bit_cnt_reg;
        frames_left_next = frames_left_reg;
        guard_next       = guard_reg;
        word_done_next   = 1'b0;
        load             = 1'b0;
        shift_en         = 1'b0;
        par_clr          = 1'b0;
        end_frame        = 1'b0;

        case (state_reg)
            IDLE: begin
                guard_next = 1'b1;
                if (fifo_rd) begin
                    load             = 1'b1;
                    cfg_next         = csr[CFG_W-1:0];
                    frames_left_next = frames_minus_one(eff_nbits(csr[CSR_NBITS_MSB:CSR_NBITS_LSB]));
                    state_next       = START;
                end
            end
            START: begin
                par_clr      = 1'b1;
                bit_cnt_next = '0;
                state_next   = DATA;
            end
            DATA: begin
                shift_en     = 1'b1;
                bit_cnt_next = bit_cnt_reg + 3'd1;
                if (last_data) begin
                    state_next = cfg_reg[CSR_PAR_EN] ? PARITY : STOP1;
                end
            end
            PARITY: state_next = STOP1;
            STOP1: begin
                if (cfg_reg[CSR_STOP2]) begin
                    state_next = STOP2;
                end else begin
                    end_frame = 1'b1;
                end
            end
            STOP2:   end_frame  = 1'b1;
            default: state_next = IDLE;
        endcase

        // The next frame follows the stop bit directly; only the word boundary idles.
        if (end_frame) begin
            if (frames_left_reg != 3'd0) begin
                frames_left_next = frames_left_reg - 3'd1;
                state_next       = START;
            end else begin
                state_next     = IDLE;
                word_done_next = 1'b1;
                guard_next     = 1'b0;
            end
        end
    end

    always_comb begin
        out = 1'b1;
        case (state_reg)
            START:   out = 1'b0;
            DATA:    out = data_bit;
            PARITY:  out = parity ^ cfg_reg[CSR_PAR_ODD];
            default: out = 1'b1;
        endcase
    end

endmodule
